// File: rtl/move_engine_if.sv
// Handshake and board bus between the 2048 move engine and its current-state register.
interface move_engine_if;
    logic                   start;
    logic [1:0]             dir;
    logic                   new_game;
    logic [3:0][3:0][11:0]  matrix_in;
    logic [2:0]             next_state;
    logic [3:0][3:0][11:0]  next_matrix;
    logic                   done;
    logic                   moved;
    logic [15:0]            score;

    modport master (
        output start, dir, new_game, matrix_in,
        input  next_state, next_matrix, done, moved, score
    );

    modport slave (
        input  start, dir, new_game, matrix_in,
        output next_state, next_matrix, done, moved, score
    );
endinterface

// File: rtl/move_engine.sv
// 2048 next-state stage: slides/merges one line per cycle, spawns an LFSR-placed tile,
// and classifies the resulting board as playable, won or lost.
module move_engine #(
    parameter logic [11:0] WIN_TILE  = 12'd2048,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst,
    move_engine_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_SPAWN = 3'd3,
        S_CHECK = 3'd4,
        S_WIN   = 3'd5,
        S_LOSE  = 3'd6
    } state_t;

    state_t                 state;
    logic [3:0][3:0][11:0]  board;
    logic [1:0]             line_idx;
    logic [1:0]             dir_q;
    logic                   ng_pend;
    logic                   spawn_two;
    logic [15:0]            lfsr;
    logic [15:0]            score;
    logic                   moved;
    logic                   done;

    logic [15:0]            lfsr_next;
    logic [3:0][11:0]       line_in;
    logic [3:0][11:0]       comp;
    logic [3:0][11:0]       merged;
    logic [3:0][11:0]       line_out;
    logic [1:0]             cnt;
    logic [13:0]            gain;
    logic                   line_changed;
    logic [3:0][3:0][11:0]  shift_board;
    logic [16:0]            score_sum;
    logic [15:0]            score_next;
    logic [3:0][3:0][11:0]  spawn_board;
    logic [3:0]             cand;
    logic [3:0]             spawn_idx;
    logic                   spawn_ok;
    logic                   has_win;
    logic                   has_empty;
    logic                   has_pair;

    assign bus.next_state  = state;
    assign bus.next_matrix = board;
    assign bus.done        = done;
    assign bus.moved       = moved;
    assign bus.score       = score;

    assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

    // One line: gather from the destination edge, compress, merge once, compress again.
    always_comb begin
        line_in = '0;
        for (int p = 0; p < 4; p++) begin
            case (dir_q)
                2'b00:   line_in[2'(p)] = board[2'(p)][line_idx];
                2'b01:   line_in[2'(p)] = board[2'(3 - p)][line_idx];
                2'b10:   line_in[2'(p)] = board[line_idx][2'(p)];
                default: line_in[2'(p)] = board[line_idx][2'(3 - p)];
            endcase
        end

        comp = '0;
        cnt  = '0;
        for (int p = 0; p < 4; p++) begin
            if (line_in[2'(p)] != 12'd0) begin
                comp[cnt] = line_in[2'(p)];
                cnt       = cnt + 2'd1;
            end
        end

        merged = comp;
        gain   = '0;
        for (int p = 0; p < 3; p++) begin
            if (merged[2'(p)] != 12'd0 && merged[2'(p)] == merged[2'(p + 1)]) begin
                gain              = gain + {1'b0, merged[2'(p)], 1'b0};
                merged[2'(p)]     = 12'(merged[2'(p)] << 1);
                merged[2'(p + 1)] = '0;
            end
        end

        line_out = '0;
        cnt      = '0;
        for (int p = 0; p < 4; p++) begin
            if (merged[2'(p)] != 12'd0) begin
                line_out[cnt] = merged[2'(p)];
                cnt           = cnt + 2'd1;
            end
        end

        line_changed = (line_out != line_in);

        shift_board = board;
        for (int p = 0; p < 4; p++) begin
            case (dir_q)
                2'b00:   shift_board[2'(p)][line_idx]     = line_out[2'(p)];
                2'b01:   shift_board[2'(3 - p)][line_idx] = line_out[2'(p)];
                2'b10:   shift_board[line_idx][2'(p)]     = line_out[2'(p)];
                default: shift_board[line_idx][2'(3 - p)] = line_out[2'(p)];
            endcase
        end

        score_sum  = {1'b0, score} + 17'(gain);
        score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end

    // Spawn: first empty cell scanning upward from LFSR[3:0], wrapping mod 16.
    always_comb begin
        spawn_idx = '0;
        spawn_ok  = 1'b0;
        cand      = '0;
        for (int j = 0; j < 16; j++) begin
            cand = lfsr[3:0] + 4'(j);
            if (!spawn_ok && board[cand[3:2]][cand[1:0]] == 12'd0) begin
                spawn_ok  = 1'b1;
                spawn_idx = cand;
            end
        end
        spawn_board = board;
        if (spawn_ok)
            spawn_board[spawn_idx[3:2]][spawn_idx[1:0]] = (lfsr[7:4] == 4'd0) ? 12'd4 : 12'd2;
    end

    always_comb begin
        has_win   = 1'b0;
        has_empty = 1'b0;
        has_pair  = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (board[2'(r)][2'(c)] >= WIN_TILE) has_win = 1'b1;
                if (board[2'(r)][2'(c)] == 12'd0)    has_empty = 1'b1;
                if (c < 3 && board[2'(r)][2'(c)] == board[2'(r)][2'(c + 1)]) has_pair = 1'b1;
                if (r < 3 && board[2'(r)][2'(c)] == board[2'(r + 1)][2'(c)]) has_pair = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            board     <= '0;
            line_idx  <= '0;
            dir_q     <= '0;
            ng_pend   <= 1'b0;
            spawn_two <= 1'b0;
            lfsr      <= LFSR_SEED;
            score     <= '0;
            moved     <= 1'b0;
            done      <= 1'b0;
        end else begin
            lfsr <= lfsr_next;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // ng_pend holds the cleared board for one cycle before the two spawns.
                    if (ng_pend) begin
                        ng_pend   <= 1'b0;
                        spawn_two <= 1'b1;
                        state     <= S_SPAWN;
                    end else if (bus.new_game) begin
                        board   <= '0;
                        score   <= '0;
                        ng_pend <= 1'b1;
                    end else begin
                        board <= bus.matrix_in;
                        if (bus.start) begin
                            dir_q <= bus.dir;
                            state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    board    <= bus.matrix_in;
                    moved    <= 1'b0;
                    line_idx <= '0;
                    state    <= S_SHIFT;
                end
                S_SHIFT: begin
                    board    <= shift_board;
                    score    <= score_next;
                    line_idx <= line_idx + 2'd1;
                    if (line_changed) moved <= 1'b1;
                    if (line_idx == 2'd3)
                        state <= (moved || line_changed) ? S_SPAWN : S_CHECK;
                end
                S_SPAWN: begin
                    board <= spawn_board;
                    if (spawn_two) spawn_two <= 1'b0;
                    else           state     <= S_CHECK;
                end
                S_CHECK: begin
                    done <= 1'b1;
                    if (has_win)                     state <= S_WIN;
                    else if (!has_empty && !has_pair) state <= S_LOSE;
                    else                             state <= S_IDLE;
                end
                S_WIN, S_LOSE: begin
                    if (bus.new_game) begin
                        board   <= '0;
                        score   <= '0;
                        ng_pend <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_move_engine.sv
// Self-checking bench for move_engine: directed 2048 scenarios plus random boards
// compared against a queue-based game model and an LFSR model.
module tb_move_engine;
    typedef logic [3:0][3:0][11:0] board_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_SPAWN = 3'd3;
    localparam logic [2:0] ST_CHECK = 3'd4;
    localparam logic [2:0] ST_WIN   = 3'd5;
    localparam logic [2:0] ST_LOSE  = 3'd6;
    localparam int         WIN_VAL  = 2048;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] m_lfsr;
    int          checks = 0;
    int          errors = 0;
    int          exp_score = 0;

    move_engine_if bus();

    move_engine #(.WIN_TILE(12'd2048), .LFSR_SEED(16'hACE1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        int v;
        int fb;
        v  = int'(l);
        fb = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
        return 16'((v >> 1) + fb * 32768);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= lfsr_step(m_lfsr);
    end

    function automatic void cell_of(input logic [1:0] d, input int i, input int p,
                                    output int r, output int c);
        case (d)
            2'b00:   begin r = p;     c = i;     end
            2'b01:   begin r = 3 - p; c = i;     end
            2'b10:   begin r = i;     c = p;     end
            default: begin r = i;     c = 3 - p; end
        endcase
    endfunction

    function automatic void model_move(input board_t b, input logic [1:0] d,
                                       output board_t o, output int gain, output bit mv);
        int nz[$];
        int outl[4];
        int k, r, c;
        o = b;
        gain = 0;
        for (int i = 0; i < 4; i++) begin
            nz = {};
            for (int p = 0; p < 4; p++) begin
                cell_of(d, i, p, r, c);
                if (b[r][c] != 0) nz.push_back(int'(b[r][c]));
            end
            k = 0;
            while (nz.size() > 0) begin
                if (nz.size() >= 2 && nz[0] == nz[1]) begin
                    outl[k] = nz[0] * 2;
                    gain += nz[0] * 2;
                    void'(nz.pop_front());
                    void'(nz.pop_front());
                end else begin
                    outl[k] = nz.pop_front();
                end
                k++;
            end
            while (k < 4) begin
                outl[k] = 0;
                k++;
            end
            for (int p = 0; p < 4; p++) begin
                cell_of(d, i, p, r, c);
                o[r][c] = 12'(outl[p]);
            end
        end
        mv = (o != b);
    endfunction

    function automatic board_t model_spawn(input board_t b, input logic [15:0] lf);
        board_t o;
        int st;
        int idx;
        o  = b;
        st = int'(lf) % 16;
        for (int j = 0; j < 16; j++) begin
            idx = (st + j) % 16;
            if (o[idx / 4][idx % 4] == 0) begin
                o[idx / 4][idx % 4] = (((int'(lf) / 16) % 16) == 0) ? 12'd4 : 12'd2;
                return o;
            end
        end
        return o;
    endfunction

    function automatic logic [2:0] model_check(input board_t b);
        bit win = 0, empty = 0, pair = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                if (int'(b[r][c]) >= WIN_VAL) win = 1;
                if (b[r][c] == 0) empty = 1;
                if (c < 3 && b[r][c] == b[r][c + 1]) pair = 1;
                if (r < 3 && b[r][c] == b[r + 1][c]) pair = 1;
            end
        if (win) return ST_WIN;
        if (!empty && !pair) return ST_LOSE;
        return ST_IDLE;
    endfunction

    function automatic int count_nz(input board_t b);
        int n = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (b[r][c] != 0) n++;
        return n;
    endfunction

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    // Issues one move and watches 12 edges; results are latched at the first done pulse.
    task automatic run_move(input board_t b, input logic [1:0] d, output board_t res,
                            output int done_at, output int done_cnt, output logic [2:0] fin,
                            output logic mv, output logic [15:0] sc, output logic [15:0] lf5);
        @(negedge clk);
        bus.matrix_in = b;
        bus.dir       = d;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        done_at = -1; done_cnt = 0; res = '0; fin = 3'd7; mv = 1'bx; sc = 'x; lf5 = '0;
        for (int j = 1; j <= 12; j++) begin
            @(posedge clk); #1;
            if (j == 5) lf5 = m_lfsr;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = j;
                    res = bus.next_matrix;
                    fin = bus.next_state;
                    mv  = bus.moved;
                    sc  = bus.score;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.new_game = 1'b0; bus.dir = 2'b00; bus.matrix_in = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.next_state !== ST_IDLE || bus.next_matrix !== '0 || bus.done !== 1'b0 ||
            bus.moved !== 1'b0 || bus.score !== 16'd0) begin
            errors++;
            $display("FAIL reset_values: state=%0d board=%h done=%b moved=%b score=%0d, required all zero",
                     bus.next_state, bus.next_matrix, bus.done, bus.moved, bus.score);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_score = 0;
    endtask

    task automatic test_idle_track();
        board_t b;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                b[r][c] = 12'(2 << $urandom_range(0, 5));
        @(negedge clk);
        bus.matrix_in = b;
        @(posedge clk); #1;
        checks++;
        if (bus.next_matrix !== b || bus.next_state !== ST_IDLE) begin
            errors++;
            $display("FAIL idle_track: board=%h state=%0d, required %h state 0",
                     bus.next_matrix, bus.next_state, b);
        end
        @(negedge clk);
        bus.matrix_in = '0;
    endtask

    task automatic test_left_merge();
        board_t b, res, o, e;
        int dat, dcnt, g;
        bit mm;
        logic [2:0] fin;
        logic mv;
        logic [15:0] sc, lf5;
        b = '0;
        for (int c = 0; c < 4; c++) b[0][c] = 12'd2;
        run_move(b, 2'b10, res, dat, dcnt, fin, mv, sc, lf5);
        model_move(b, 2'b10, o, g, mm);
        e = model_spawn(o, lf5);
        exp_score = sat16(exp_score + g);
        checks++;
        if (res[0][0] !== 12'd4 || res[0][1] !== 12'd4) begin
            errors++;
            $display("FAIL left_merge_row: row0=%0d,%0d required 4,4", res[0][0], res[0][1]);
        end
        checks++;
        if (sc !== 16'd8 || mv !== 1'b1) begin
            errors++;
            $display("FAIL left_merge_score: score=%0d moved=%b required 8 and 1", sc, mv);
        end
        checks++;
        if (res !== e || count_nz(res) != 3) begin
            errors++;
            $display("FAIL left_merge_spawn: board=%h required %h", res, e);
        end
        checks++;
        if (dat != 7 || dcnt != 1 || fin !== ST_IDLE) begin
            errors++;
            $display("FAIL left_merge_timing: done_at=%0d count=%0d state=%0d required 7 1 0", dat, dcnt, fin);
        end
    endtask

    task automatic test_no_double_merge();
        board_t b, res, o, e;
        int dat, dcnt, g;
        bit mm;
        logic [2:0] fin;
        logic mv;
        logic [15:0] sc, lf5;
        b = '0;
        b[1][0] = 12'd2; b[1][2] = 12'd2; b[1][3] = 12'd4;
        run_move(b, 2'b11, res, dat, dcnt, fin, mv, sc, lf5);
        model_move(b, 2'b11, o, g, mm);
        e = model_spawn(o, lf5);
        exp_score = sat16(exp_score + g);
        checks++;
        if (res[1][2] !== 12'd4 || res[1][3] !== 12'd4) begin
            errors++;
            $display("FAIL no_double_merge_row: cols2..3=%0d,%0d required 4,4", res[1][2], res[1][3]);
        end
        checks++;
        if (sc !== 16'd12) begin
            errors++;
            $display("FAIL no_double_merge_score: score=%0d required 12", sc);
        end
        checks++;
        if (res !== e || dat != 7) begin
            errors++;
            $display("FAIL no_double_merge_board: board=%h done_at=%0d required %h at 7", res, dat, e);
        end
    endtask

    task automatic test_no_move();
        board_t b, res;
        int dat, dcnt;
        logic [2:0] fin;
        logic mv;
        logic [15:0] sc, lf5;
        b = '0;
        b[0][0] = 12'd2; b[1][0] = 12'd4; b[2][0] = 12'd8; b[3][0] = 12'd16;
        run_move(b, 2'b00, res, dat, dcnt, fin, mv, sc, lf5);
        checks++;
        if (mv !== 1'b0 || res !== b) begin
            errors++;
            $display("FAIL no_move_board: moved=%b board=%h required 0 and %h", mv, res, b);
        end
        checks++;
        if (dat != 6 || fin !== ST_IDLE || sc !== 16'(exp_score)) begin
            errors++;
            $display("FAIL no_move_timing: done_at=%0d state=%0d score=%0d required 6 0 %0d",
                     dat, fin, sc, exp_score);
        end
    endtask

    task automatic test_lose();
        board_t b, res;
        int dat, dcnt;
        logic [2:0] fin;
        logic mv;
        logic [15:0] sc, lf5;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                b[r][c] = ((r + c) % 2 == 1) ? 12'd4 : 12'd2;
        run_move(b, 2'($urandom_range(0, 3)), res, dat, dcnt, fin, mv, sc, lf5);
        checks++;
        if (mv !== 1'b0 || fin !== ST_LOSE || dcnt != 1 || dat != 6) begin
            errors++;
            $display("FAIL lose: moved=%b state=%0d done_count=%0d done_at=%0d required 0 6 1 6",
                     mv, fin, dcnt, dat);
        end
    endtask

    task automatic test_new_game();
        logic [15:0] lf1, lf2;
        logic [2:0] st[1:4];
        logic dn[1:4];
        board_t e;
        @(negedge clk);
        bus.new_game = 1'b1;
        @(posedge clk); #1;
        bus.new_game = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            @(posedge clk); #1;
            if (j == 1) lf1 = m_lfsr;
            if (j == 2) lf2 = m_lfsr;
            st[j] = bus.next_state;
            dn[j] = bus.done;
        end
        e = model_spawn(model_spawn('0, lf1), lf2);
        exp_score = 0;
        checks++;
        if (st[1] !== ST_SPAWN || st[2] !== ST_SPAWN || st[3] !== ST_CHECK || st[4] !== ST_IDLE || dn[4] !== 1'b1) begin
            errors++;
            $display("FAIL new_game_seq: states=%0d,%0d,%0d,%0d done=%b required 3,3,4,0 done 1",
                     st[1], st[2], st[3], st[4], dn[4]);
        end
        checks++;
        if (bus.next_matrix !== e || count_nz(bus.next_matrix) != 2 || bus.score !== 16'd0) begin
            errors++;
            $display("FAIL new_game_board: board=%h score=%0d required %h score 0",
                     bus.next_matrix, bus.score, e);
        end
    endtask

    task automatic test_win();
        board_t b, res, o, e;
        int dat, dcnt, g;
        bit mm;
        logic [2:0] fin;
        logic mv;
        logic [15:0] sc, lf5;
        b = '0;
        b[0][0] = 12'd1024; b[0][1] = 12'd1024;
        run_move(b, 2'b10, res, dat, dcnt, fin, mv, sc, lf5);
        model_move(b, 2'b10, o, g, mm);
        e = model_spawn(o, lf5);
        exp_score = sat16(exp_score + g);
        checks++;
        if (fin !== ST_WIN || res !== e || sc !== 16'(exp_score) || dat != 7) begin
            errors++;
            $display("FAIL win: state=%0d board=%h score=%0d done_at=%0d required 5 %h %0d 7",
                     fin, res, sc, dat, e, exp_score);
        end
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (bus.next_state !== ST_WIN || bus.done !== 1'b0 || bus.next_matrix !== e) begin
            errors++;
            $display("FAIL win_start_ignored: state=%0d done=%b required 5 and 0", bus.next_state, bus.done);
        end
    endtask

    task automatic test_reset_mid_shift();
        board_t b;
        b = '0;
        b[2][1] = 12'd8; b[2][3] = 12'd8;
        @(negedge clk);
        bus.matrix_in = b; bus.dir = 2'b10; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.next_state !== ST_SHIFT) begin
            errors++;
            $display("FAIL mid_shift_state: state=%0d required 2", bus.next_state);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.next_state !== ST_IDLE || bus.next_matrix !== '0 || bus.score !== 16'd0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL mid_shift_reset: state=%0d board=%h score=%0d done=%b required all zero",
                     bus.next_state, bus.next_matrix, bus.score, bus.done);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.matrix_in = '0;
        exp_score = 0;
    endtask

    task automatic test_random();
        board_t b, res, o, e;
        int dat, dcnt, g;
        bit mm;
        logic [1:0] d;
        logic [2:0] fin, efin;
        logic mv;
        logic [15:0] sc, lf5;
        for (int it = 0; it < 30; it++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    b[r][c] = ($urandom_range(0, 2) == 0) ? 12'd0 : 12'(2 << $urandom_range(0, 3));
            b[$urandom_range(0, 3)][0] = 12'd0;
            b[$urandom_range(0, 3)][3] = 12'd0;
            d = 2'($urandom_range(0, 3));
            run_move(b, d, res, dat, dcnt, fin, mv, sc, lf5);
            model_move(b, d, o, g, mm);
            e = mm ? model_spawn(o, lf5) : o;
            efin = model_check(e);
            exp_score = sat16(exp_score + g);
            checks++;
            if (res !== e || mv !== logic'(mm) || sc !== 16'(exp_score) || fin !== efin ||
                dat != (mm ? 7 : 6) || dcnt != 1) begin
                errors++;
                $display("FAIL random_move[%0d]: dir=%0d board=%h moved=%b score=%0d state=%0d done_at=%0d; required %h %b %0d %0d %0d",
                         it, d, res, mv, sc, fin, dat, e, mm, exp_score, efin, mm ? 7 : 6);
            end
        end
    endtask

    task automatic test_start_held();
        board_t b;
        logic [2:0] st[0:8];
        logic dn[0:8];
        b = '0;
        b[2][0] = 12'd2; b[2][1] = 12'd2;
        @(negedge clk);
        bus.matrix_in = b; bus.dir = 2'b10; bus.start = 1'b1;
        @(posedge clk); #1;
        st[0] = bus.next_state; dn[0] = bus.done;
        for (int j = 1; j <= 8; j++) begin
            @(posedge clk); #1;
            st[j] = bus.next_state;
            dn[j] = bus.done;
        end
        bus.start = 1'b0;
        checks++;
        if (st[0] !== ST_LOAD || st[1] !== ST_SHIFT || st[5] !== ST_SPAWN || st[6] !== ST_CHECK) begin
            errors++;
            $display("FAIL start_held_busy: states=%0d,%0d,%0d,%0d required 1,2,3,4", st[0], st[1], st[5], st[6]);
        end
        checks++;
        if (st[7] !== ST_IDLE || dn[7] !== 1'b1 || st[8] !== ST_LOAD || dn[8] !== 1'b0) begin
            errors++;
            $display("FAIL start_held_retrigger: k7=%0d/%b k8=%0d/%b required 0/1 1/0", st[7], dn[7], st[8], dn[8]);
        end
        repeat (10) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_idle_track();
        test_left_merge();
        test_no_double_merge();
        test_no_move();
        test_lose();
        test_new_game();
        test_win();
        test_new_game();
        test_reset_mid_shift();
        test_random();
        test_start_held();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
